// File: rtl/reclock_pkg.sv
// Shared constants and per-channel control state for the reclock bank.
package reclock_pkg;

  localparam int unsigned NChDefault  = 4;
  localparam int unsigned DivWDefault = 8;

  // run is clear until the first enabled edge after reset or disable.
  typedef struct packed {
    logic run;
    logic out;
    logic tick;
    logic pending;
  } ch_flags_t;

endpackage

// File: rtl/reclock_channel.sv
// One divided-clock channel: half-period of act_div+1 cycles, with
// divisor changes deferred to the next wrap.
module reclock_channel
  import reclock_pkg::*;
#(
  parameter int unsigned DIV_W = DivWDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             out_o,
  output logic             tick_o,
  output logic             pending_o
);

  localparam logic [DIV_W-1:0] One = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] cur_div;
  ch_flags_t        fl_q, fl_d;

  always_comb begin
    // The first enabled edge uses the live divisor, so a channel coming out
    // of reset behaves exactly like one whose enable just rose.
    cur_div = fl_q.run ? act_q : div_i;
    cnt_d   = cnt_q;
    act_d   = act_q;
    fl_d    = fl_q;
    if (!en_i) begin
      cnt_d = '0;
      act_d = div_i;
      fl_d  = '0;
    end else if (sync_i) begin
      cnt_d = '0;
      act_d = div_i;
      fl_d  = '{run: 1'b1, out: 1'b0, tick: 1'b0, pending: 1'b0};
    end else if (cnt_q == cur_div) begin
      cnt_d = '0;
      act_d = div_i;
      fl_d  = '{run: 1'b1, out: ~fl_q.out, tick: 1'b1, pending: 1'b0};
    end else begin
      cnt_d        = cnt_q + One;
      act_d        = cur_div;
      fl_d.run     = 1'b1;
      fl_d.tick    = 1'b0;
      fl_d.pending = (div_i != cur_div);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      act_q <= '0;
      fl_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      fl_q  <= fl_d;
    end
  end

  assign out_o     = fl_q.out;
  assign tick_o    = fl_q.tick;
  assign pending_o = fl_q.pending;

endmodule

// File: rtl/reclock_bank.sv
// Bank of independent divided-clock channels sharing one phase-align strobe.
module reclock_bank
  import reclock_pkg::*;
#(
  parameter int unsigned N_CH  = NChDefault,
  parameter int unsigned DIV_W = DivWDefault
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [N_CH-1:0]       enable,
  input  logic [N_CH*DIV_W-1:0] divisor,
  input  logic                  sync,
  output logic [N_CH-1:0]       out,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       pending
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    reclock_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk_i    (CLK),
      .rst_ni   (RST_N),
      .en_i     (enable[i]),
      .sync_i   (sync),
      .div_i    (divisor[i*DIV_W +: DIV_W]),
      .out_o    (out[i]),
      .tick_o   (tick[i]),
      .pending_o(pending[i])
    );
  end

endmodule

// File: tb/tb_reclock_bank.sv
// Randomized and directed bench for reclock_bank against a countdown model.
module tb_reclock_bank;

  localparam int NCH = 2;
  localparam int DW  = 4;

  logic              CLK;
  logic              RST_N;
  logic [NCH-1:0]    enable;
  logic [NCH*DW-1:0] divisor;
  logic              sync;
  logic [NCH-1:0]    out;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    pending;

  int n_chk = 0;
  int n_err = 0;

  reclock_bank #(
    .N_CH (NCH),
    .DIV_W(DW)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .enable (enable),
    .divisor(divisor),
    .sync   (sync),
    .out    (out),
    .tick   (tick),
    .pending(pending)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model: each channel counts down the cycles left in its half-period.
  bit m_idle[NCH];
  bit m_out[NCH];
  bit m_tick[NCH];
  bit m_pend[NCH];
  int m_cur[NCH];
  int m_left[NCH];

  always @(posedge CLK or negedge RST_N) begin
    int d;
    if (!RST_N) begin
      for (int c = 0; c < NCH; c++) begin
        m_idle[c] = 1'b1;
        m_out[c]  = 1'b0;
        m_tick[c] = 1'b0;
        m_pend[c] = 1'b0;
        m_cur[c]  = 0;
        m_left[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        d = int'(divisor[c*DW +: DW]);
        if (!enable[c]) begin
          m_idle[c] = 1'b1;
          m_out[c]  = 1'b0;
          m_tick[c] = 1'b0;
          m_pend[c] = 1'b0;
          m_cur[c]  = d;
        end else if (sync) begin
          m_idle[c] = 1'b0;
          m_out[c]  = 1'b0;
          m_tick[c] = 1'b0;
          m_pend[c] = 1'b0;
          m_cur[c]  = d;
          m_left[c] = d + 1;
        end else begin
          if (m_idle[c]) begin
            m_idle[c] = 1'b0;
            m_cur[c]  = d;
            m_left[c] = d + 1;
          end
          m_left[c] = m_left[c] - 1;
          if (m_left[c] == 0) begin
            m_tick[c] = 1'b1;
            m_out[c]  = !m_out[c];
            m_pend[c] = 1'b0;
            m_cur[c]  = d;
            m_left[c] = d + 1;
          end else begin
            m_tick[c] = 1'b0;
            m_pend[c] = (d != m_cur[c]);
          end
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp_all();
    for (int c = 0; c < NCH; c++) begin
      check_eq($sformatf("out%0d", c), 32'(out[c]), 32'(m_out[c]));
      check_eq($sformatf("tick%0d", c), 32'(tick[c]), 32'(m_tick[c]));
      check_eq($sformatf("pending%0d", c), 32'(pending[c]), 32'(m_pend[c]));
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge CLK);
      cmp_all();
    end
  endtask

  task automatic set_div(input int c, input int v);
    divisor[c*DW +: DW] = 4'(v);
  endtask

  initial begin
    RST_N   = 1'b0;
    enable  = '0;
    divisor = '0;
    sync    = 1'b0;
    #12;
    check_eq("reset_out", 32'(out), 32'd0);
    check_eq("reset_tick", 32'(tick), 32'd0);
    check_eq("reset_pending", 32'(pending), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc(2);

    // Fastest divide, then a slower one.
    set_div(0, 0);
    enable = 2'b01;
    cyc(8);
    enable[0] = 1'b0;
    cyc(1);
    set_div(0, 3);
    enable[0] = 1'b1;
    cyc(20);

    // Divisor change at cnt=1 is deferred to the next wrap.
    enable[0] = 1'b0;
    cyc(1);
    enable[0] = 1'b1;
    cyc(1);
    set_div(0, 1);
    cyc(12);

    // Sync on a ch0 wrap cycle.
    enable = 2'b00;
    cyc(1);
    set_div(0, 1);
    set_div(1, 2);
    enable = 2'b11;
    cyc(1);
    sync = 1'b1;
    cyc(1);
    sync = 1'b0;
    cyc(10);

    // Disable ch1 at cnt=2, then re-enable.
    enable = 2'b00;
    cyc(1);
    enable = 2'b10;
    cyc(2);
    enable[1] = 1'b0;
    cyc(2);
    enable[1] = 1'b1;
    cyc(8);

    // Largest divisor.
    set_div(1, 15);
    enable[1] = 1'b0;
    cyc(1);
    enable[1] = 1'b1;
    cyc(70);

    // Asynchronous reset mid-period with a divisor change pending.
    enable = 2'b00;
    cyc(1);
    set_div(0, 3);
    enable = 2'b01;
    cyc(5);
    set_div(0, 5);
    @(posedge CLK);
    #2;
    check_eq("pre_reset_out0", 32'(out[0]), 32'd1);
    check_eq("pre_reset_pending0", 32'(pending[0]), 32'd1);
    RST_N = 1'b0;
    #1;
    check_eq("async_out", 32'(out), 32'd0);
    check_eq("async_tick", 32'(tick), 32'd0);
    check_eq("async_pending", 32'(pending), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc(20);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      @(negedge CLK);
      cmp_all();
      sync = ($urandom_range(0, 31) == 0);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 23) == 0) enable[c] = ~enable[c];
        if ($urandom_range(0, 9) == 0) set_div(c, int'($urandom_range(0, 15)));
      end
    end
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
